inst_mem_resp: RTL and testbench
================================

# inst_mem_resp

Responder end of the instruction bus: accepts `ibus_req_t` requests from the fetch stage, looks the instruction up in a word-addressed on-chip array, and returns it on `ibus_resp_t` after a fixed, parameterised latency. It stands in for the instruction memory in simulation and FPGA builds, so fetch can be exercised without the full bus/cache path. A side-band preload port fills the array before or between runs.

## Interface
- `DEPTH` — 1024 — number of 32-bit instruction words; power of two, ≥ 2.
- `LATENCY` — 2 — cycles from request accept to response cycle; range 1..15.
- `BASE` — `PCINIT` — byte address of word index 0.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ireq`  in  `ibus_req_t`  request (`valid`, `addr` as `addr_t`) from fetch.
- `iresp`  out  `ibus_resp_t`  response (`addr_ok`, `data_ok`, `data` 32-bit).
- `ld_en`  in  1  preload write strobe.
- `ld_idx`  in  $clog2(DEPTH)  preload word index.
- `ld_data`  in  32  preload word.
- `fault`  out  1  sticky: some request was misaligned or out of range.
- `resp_cnt`  out  32  number of responses issued, wraps at 2^32.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if `ireq.valid`, latch `ireq.addr` into `req_addr`, load `cnt = LATENCY-1`; go to RESP if `cnt == 0`, else WAIT. Otherwise stay.
- WAIT: if `ireq.valid == 0`, abort and go to IDLE with no response. Otherwise decrement `cnt`; go to RESP when it reaches 0.
- RESP: `iresp.addr_ok = iresp.data_ok = 1` for exactly this one cycle, `iresp.data` valid. Go to IDLE unconditionally.
- Address check on `req_addr`:
  - `off = req_addr - BASE` (64-bit unsigned).
  - Valid iff `req_addr >= BASE`, `off[1:0] == 0`, and `off[63:2] < DEPTH`.
  - Index = `off[$clog2(DEPTH)+1:2]`.
- Array read on the edge entering RESP; result registered into `iresp.data`.
- Invalid address: `iresp.data = 32'h0000_0000`, response still issued, `fault` set and held until reset.
- Preload: when `ld_en`, write `ld_data` to `mem[ld_idx]` at the edge, independent of FSM state.
  - Read and write of the same index on the same edge: read returns the OLD word.
- The array is not cleared by reset; contents survive `rst_n`.
- `resp_cnt` increments on every edge leaving RESP.

## Timing
- Reset values, all asynchronous on `rst_n = 0`:
  - state IDLE, `iresp.addr_ok = 0`, `iresp.data_ok = 0`, `iresp.data = 0`, `fault = 0`, `resp_cnt = 0`, `cnt = 0`.
- Accept at edge T (IDLE sampling `valid = 1`) gives the response cycle as the cycle after edge T+LATENCY−1, i.e. exactly LATENCY cycles after the accept cycle.
- `addr_ok` and `data_ok` are always asserted together; neither is ever asserted outside RESP.
- At least one IDLE cycle separates consecutive responses.
- If `ireq.valid` is still high in that IDLE cycle, a new request is accepted with the current `ireq.addr`. Minimum back-to-back period is LATENCY+1 cycles.
- Changes on `ireq.addr` after accept are ignored.
- Reset asserted mid-transaction: response dropped, no `data_ok` pulse, next request after release starts from IDLE.
- All outputs are registered; no combinational path from `ireq` to `iresp`.

## Test plan
- Reset then preload: preload `mem[0] = 32'h0000_0013`, `mem[1] = 32'h0010_0093`; request `addr = BASE` with LATENCY=2 → `addr_ok = data_ok = 1`, `data = 32'h0000_0013` exactly 2 cycles after accept; `resp_cnt = 1`.
- Fetch-style loop: initiator re-requests `BASE+4` after a one-cycle valid drop → `data = 32'h0010_0093`, one-cycle ok pulse, `resp_cnt = 2`, `fault = 0`.
- Faults:
  - request `BASE+2` → `data = 0`, `fault = 1`;
  - request `BASE + 4*DEPTH` → `data = 0`, `fault` stays 1 until reset;
  - request `BASE - 4` → `data = 0`, `fault = 1`.
- Abort and reset: with LATENCY=4, drop `valid` in WAIT → no ok pulse, next accept is clean. Pull `rst_n` low in WAIT → all outputs 0 immediately, array contents intact on a later read.
- Preload collision: `ld_en` to index 1 with `ld_data = 32'hDEAD_BEEF` on the RESP-entry edge of a read to index 1 → old word returned; a second read returns `32'hDEAD_BEEF`.
- LATENCY=1 with `valid` held high continuously → one response every 2 cycles. Wrap check: force `resp_cnt` to `32'hFFFF_FFFF`, one response → 0.

Source files
------------

// File: rtl/inst_mem_resp_pkg.sv
// inst_mem_resp_pkg: instruction-bus request/response types and the reset fetch address
package inst_mem_resp_pkg;

    typedef logic [63:0] addr_t;

    localparam addr_t PCINIT = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

// File: rtl/inst_mem_resp.sv
// inst_mem_resp: fixed-latency instruction memory responder with side-band preload
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset (array contents are kept)
//   ireq      fetch request: valid, byte address
//   iresp     response: addr_ok/data_ok one-cycle pulse, 32-bit instruction word
//   ld_en     preload strobe, writes ld_data to mem[ld_idx]
//   fault     sticky flag: a responded request was misaligned or out of range
//   resp_cnt  count of responses issued, wraps
module inst_mem_resp
    import inst_mem_resp_pkg::*;
#(
    parameter int    DEPTH   = 1024,
    parameter int    LATENCY = 2,
    parameter addr_t BASE    = PCINIT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  ibus_req_t                ireq,
    output ibus_resp_t               iresp,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [31:0]              ld_data,
    output logic                     fault,
    output logic [31:0]              resp_cnt
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    addr_t         req_addr;
    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH];

    addr_t         rd_addr;
    addr_t         off;
    logic          rd_ok;
    logic [IW-1:0] rd_idx;
    logic          go;

    // With LATENCY=1 the array is read on the accept edge itself, before
    // req_addr has been loaded, so the lookup address comes straight off the bus.
    always_comb begin
        rd_addr = (state == IDLE) ? ireq.addr : req_addr;
        off     = rd_addr - BASE;
        rd_ok   = (rd_addr >= BASE) && (off[1:0] == 2'b00) && (off[63:IW+2] == '0);
        rd_idx  = off[IW+1:2];
        go      = ireq.valid && (((state == IDLE) && (LATENCY == 1)) ||
                                 ((state == WAIT) && (cnt == 4'd1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_addr <= '0;
            cnt      <= '0;
            iresp    <= '0;
            fault    <= 1'b0;
            resp_cnt <= '0;
        end else begin
            iresp.addr_ok <= go;
            iresp.data_ok <= go;
            if (go) begin
                iresp.data <= rd_ok ? mem[rd_idx] : 32'h0000_0000;
                if (!rd_ok) fault <= 1'b1;
            end
            case (state)
                IDLE: if (ireq.valid) begin
                    req_addr <= ireq.addr;
                    cnt      <= 4'(LATENCY - 1);
                    state    <= go ? RESP : WAIT;
                end
                WAIT: if (!ireq.valid) begin
                    state <= IDLE;
                end else begin
                    cnt <= cnt - 4'd1;
                    if (go) state <= RESP;
                end
                RESP: begin
                    state    <= IDLE;
                    resp_cnt <= resp_cnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Nonblocking write alongside the registered read: a same-edge collision returns the old word.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
    end

endmodule

// File: tb/tb_inst_mem_resp.sv
// tb_inst_mem_resp: three responders (LATENCY 2, 4, 1) on shared stimulus, checked against a cycle-count model
module tb_inst_mem_resp;
    import inst_mem_resp_pkg::*;

    localparam int    DEPTH = 16;
    localparam addr_t BASE  = PCINIT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    ibus_req_t   ireq;
    logic        ld_en;
    logic [3:0]  ld_idx;
    logic [31:0] ld_data;
    ibus_resp_t  r2, r4, r1;
    logic        f2, f4, f1;
    logic [31:0] c2, c4, c1;

    inst_mem_resp #(.DEPTH(DEPTH), .LATENCY(2), .BASE(BASE)) u2 (
        .clk(clk), .rst_n(rst_n), .ireq(ireq), .iresp(r2), .ld_en(ld_en),
        .ld_idx(ld_idx), .ld_data(ld_data), .fault(f2), .resp_cnt(c2));
    inst_mem_resp #(.DEPTH(DEPTH), .LATENCY(4), .BASE(BASE)) u4 (
        .clk(clk), .rst_n(rst_n), .ireq(ireq), .iresp(r4), .ld_en(ld_en),
        .ld_idx(ld_idx), .ld_data(ld_data), .fault(f4), .resp_cnt(c4));
    inst_mem_resp #(.DEPTH(DEPTH), .LATENCY(1), .BASE(BASE)) u1 (
        .clk(clk), .rst_n(rst_n), .ireq(ireq), .iresp(r1), .ld_en(ld_en),
        .ld_idx(ld_idx), .ld_data(ld_data), .fault(f1), .resp_cnt(c1));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Model: each instance is either free, holding a request that must stay
    // valid until its due edge, or showing its one response cycle.
    int          lat[3] = '{2, 4, 1};
    logic [31:0] mm[DEPTH];
    bit          pend[3];
    longint      due[3];
    addr_t       ma[3];
    bit          m_ok[3];
    logic [31:0] m_data[3];
    bit          m_fault[3];
    logic [31:0] m_cnt[3];
    longint      cyc = 0;

    function automatic void respond(input int i);
        addr_t o;
        o = ma[i] - BASE;
        pend[i] = 1'b0;
        m_ok[i] = 1'b1;
        if (ma[i] >= BASE && o % 4 == 0 && o / 4 < DEPTH) begin
            m_data[i] = mm[int'(o / 4)];
        end else begin
            m_data[i]  = 32'h0;
            m_fault[i] = 1'b1;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                pend[i] = 0; m_ok[i] = 0; m_data[i] = 0; m_fault[i] = 0; m_cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_ok[i]) begin
                    m_ok[i]  = 1'b0;
                    m_cnt[i] = m_cnt[i] + 32'd1;
                end else if (pend[i]) begin
                    if (!ireq.valid) pend[i] = 1'b0;
                    else if (cyc == due[i]) respond(i);
                end else if (ireq.valid) begin
                    ma[i]   = ireq.addr;
                    due[i]  = cyc + lat[i] - 1;
                    pend[i] = 1'b1;
                    if (lat[i] == 1) respond(i);
                end
            end
            if (ld_en) mm[ld_idx] = ld_data;
            cyc++;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            ibus_resp_t r;
            logic       f;
            logic [31:0] c;
            r = (i == 0) ? r2 : (i == 1) ? r4 : r1;
            f = (i == 0) ? f2 : (i == 1) ? f4 : f1;
            c = (i == 0) ? c2 : (i == 1) ? c4 : c1;
            chk($sformatf("m%0d.addr_ok", i), r.addr_ok, m_ok[i]);
            chk($sformatf("m%0d.data_ok", i), r.data_ok, m_ok[i]);
            if (m_ok[i]) chk($sformatf("m%0d.data", i), r.data, m_data[i]);
            chk($sformatf("m%0d.fault", i), f, m_fault[i]);
            chk($sformatf("m%0d.resp_cnt", i), c, m_cnt[i]);
        end
    end

    task automatic req(input addr_t a, input int n);
        ireq.valid = 1'b1;
        ireq.addr  = a;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        ireq.valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        int b2b;
        bit prev;
        ireq = '0; ld_en = 0; ld_idx = 0; ld_data = 0;
        repeat (2) @(negedge clk);
        chk("rst_ok", {r2.addr_ok, r2.data_ok}, 0);
        chk("rst_data", r2.data, 0);
        chk("rst_fault", f2, 0);
        chk("rst_cnt", c2, 0);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ld_en = 1'b1; ld_idx = 4'(i);
            ld_data = (i == 0) ? 32'h0000_0013 : (i == 1) ? 32'h0010_0093 : 32'h1000_0000 + 32'(i);
            @(negedge clk);
        end
        ld_en = 1'b0;
        // first fetch: L=1 answers one cycle after accept, L=2 two cycles after
        req(BASE, 1);
        chk("l1_ok", r1.data_ok, 1);
        chk("l1_data", r1.data, 32'h0000_0013);
        chk("l2_early", r2.data_ok, 0);
        @(negedge clk);
        chk("t1_ok", {r2.addr_ok, r2.data_ok}, 2'b11);
        chk("t1_data", r2.data, 32'h0000_0013);
        idle(1);
        chk("t1_pulse", r2.data_ok, 0);
        chk("t1_cnt", c2, 1);
        req(BASE + 4, 2);
        chk("t2_data", r2.data, 32'h0010_0093);
        idle(1);
        chk("t2_cnt", c2, 2);
        chk("t2_fault", f2, 0);
        foreach (ma[j]) begin end
        for (int i = 0; i < 3; i++) begin
            addr_t a;
            a = (i == 0) ? BASE + 2 : (i == 1) ? BASE + 4 * DEPTH : BASE - 4;
            req(a, 2);
            chk($sformatf("flt%0d_ok", i), r2.data_ok, 1);
            chk($sformatf("flt%0d_data", i), r2.data, 0);
            chk($sformatf("flt%0d_fault", i), f2, 1);
            idle(1);
            chk($sformatf("flt%0d_sticky", i), f2, 1);
        end
        #2 rst_n = 1'b0;
        #1 chk("arst_fault", f2, 0);
        chk("arst_cnt", c2, 0);
        chk("arst_data", r2.data, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        // L=4: abort in WAIT, then a clean fetch
        req(BASE + 8, 2);
        idle(6);
        chk("abort_cnt", c4, 0);
        req(BASE, 4);
        chk("l4_ok", r4.data_ok, 1);
        chk("l4_data", r4.data, 32'h0000_0013);
        idle(1);
        chk("l4_cnt", c4, 1);
        // reset while L=4 waits
        req(BASE + 4, 2);
        #2 rst_n = 1'b0;
        #1 chk("wrst_ok", {r4.addr_ok, r4.data_ok}, 0);
        chk("wrst_data", r4.data, 0);
        chk("wrst_cnt", c4, 0);
        ireq.valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        idle(1);
        req(BASE + 4, 4);
        chk("kept_ok", r4.data_ok, 1);
        chk("kept_data", r4.data, 32'h0010_0093);
        idle(6);
        // preload to index 1 on the edge that enters RESP
        req(BASE + 4, 1);
        ld_en = 1'b1; ld_idx = 4'd1; ld_data = 32'hDEAD_BEEF;
        @(negedge clk);
        ld_en = 1'b0;
        chk("col_ok", r2.data_ok, 1);
        chk("col_old", r2.data, 32'h0010_0093);
        idle(1);
        req(BASE + 4, 2);
        chk("col_new", r2.data, 32'hDEAD_BEEF);
        idle(6);
        // L=1 with valid held: a response every other cycle
        k = 0; b2b = 0; prev = 0;
        ireq.valid = 1'b1; ireq.addr = BASE + 8;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (r1.data_ok) k++;
            if (r1.data_ok && prev) b2b++;
            prev = r1.data_ok;
        end
        chk("l1_pulses", k, 4);
        chk("l1_b2b", b2b, 0);
        idle(2);
        // resp_cnt wrap
        req(BASE, 1);
        ireq.valid = 1'b0;
        #2 force u1.resp_cnt = 32'hFFFF_FFFF;
        m_cnt[2] = 32'hFFFF_FFFF;
        #1 release u1.resp_cnt;
        @(negedge clk);
        chk("wrap", c1, 0);
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
